// File: rtl/shared_bus_pkg.sv
// Shared definitions for the tri-state bus read master: FSM encoding, select level, limits.
package shared_bus_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSel  = 2'd1,
    StTurn = 2'd2,
    StResp = 2'd3
  } state_e;

  // A chip select at this level leaves the source's bus driver in Hi-Z.
  localparam logic CsReleased = 1'b1;

  localparam int unsigned MaxSettleCycles = 15;
  localparam int unsigned CntW            = 4;

endpackage

// File: rtl/bus_cs_decoder.sv
// Index-to-active-low chip-select decoder; all selects released when disabled or out of range.
module bus_cs_decoder
  import shared_bus_pkg::*;
#(
  parameter int unsigned NrOfSources = 4,
  parameter int unsigned AddrBits    = 2
) (
  input  logic [AddrBits-1:0]    idx_i,
  input  logic                   en_i,
  output logic [NrOfSources-1:0] cs_o
);

  always_comb begin
    cs_o = {NrOfSources{CsReleased}};
    for (int unsigned i = 0; i < NrOfSources; i++) begin
      if (en_i && (idx_i == AddrBits'(i))) begin
        cs_o[i] = ~CsReleased;
      end
    end
  end

endmodule

// File: rtl/shared_bus_reader.sv
// Read master for the shared tri-state bus: select a source, settle, sample, turn around, respond.
module shared_bus_reader
  import shared_bus_pkg::*;
#(
  parameter int unsigned NrOfBits     = 32,
  parameter int unsigned NrOfSources  = 4,
  parameter int unsigned AddrBits     = 2,
  parameter int unsigned SettleCycles = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clock_enable_i,
  input  logic                   tick_i,
  input  logic                   req_valid_i,
  input  logic [AddrBits-1:0]    req_addr_i,
  output logic                   req_ready_o,
  input  logic [NrOfBits-1:0]    bus_i,
  output logic [NrOfSources-1:0] cs_o,
  output logic                   rsp_valid_o,
  output logic [NrOfBits-1:0]    rsp_data_o,
  output logic                   rsp_err_o,
  input  logic                   rsp_ready_i
);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [AddrBits-1:0]    addr_q, addr_d;
  logic [NrOfSources-1:0] cs_q, cs_d, dec_cs;
  logic [NrOfBits-1:0]    data_q, data_d;
  logic                   err_q, err_d;
  logic                   valid_q, valid_d;
  logic [AddrBits-1:0]    dec_idx;
  logic                   dec_en;
  logic                   en;
  logic                   in_range;
  logic                   last_settle;

  assign en          = clock_enable_i & tick_i;
  assign in_range    = 32'(req_addr_i) < NrOfSources;
  assign last_settle = (cnt_q == CntW'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      cs_q    <= {NrOfSources{CsReleased}};
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        StIdle:  if (req_valid_i) state_d = in_range ? StSel : StTurn;
        StSel:   if (last_settle) state_d = StTurn;
        StTurn:  state_d = StResp;
        StResp:  if (rsp_ready_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Select stays driven while in SEL until the sampling edge; every other path releases it.
  assign dec_idx = (state_q == StIdle) ? req_addr_i : addr_q;
  assign dec_en  = ((state_q == StIdle) && req_valid_i) || ((state_q == StSel) && !last_settle);

  bus_cs_decoder #(
    .NrOfSources(NrOfSources),
    .AddrBits   (AddrBits)
  ) u_cs_decoder (
    .idx_i(dec_idx),
    .en_i (dec_en),
    .cs_o (dec_cs)
  );

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = valid_q;
    cs_d    = en ? dec_cs : cs_q;
    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            addr_d = req_addr_i;
            cnt_d  = CntW'(SettleCycles);
            if (!in_range) begin
              err_d  = 1'b1;
              data_d = '0;
            end
          end
        end
        StSel: begin
          cnt_d = cnt_q - CntW'(1);
          if (last_settle) begin
            data_d = bus_i;
            err_d  = 1'b0;
          end
        end
        StTurn:  valid_d = 1'b1;
        StResp:  if (rsp_ready_i) valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign req_ready_o = (state_q == StIdle) & rst_ni;
  assign cs_o        = cs_q;
  assign rsp_valid_o = valid_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;

endmodule
